// File: rtl/time_set_ctrl.sv
// time_set_ctrl: set-mode sequencer walking clock/calendar fields, issuing load strobes and holding counters.
module time_set_ctrl #(
  parameter int HOLD_CYCLES    = 8,
  parameter int REPEAT_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cur_min,
  input  logic [4:0] cur_hour,
  input  logic [2:0] cur_day,
  input  logic [4:0] cur_date,
  input  logic [3:0] cur_month,
  input  logic [6:0] cur_year,
  output logic       ld_min,
  output logic       ld_hour,
  output logic       ld_day,
  output logic       ld_date,
  output logic       ld_month,
  output logic       ld_year,
  output logic [6:0] set_data,
  output logic       run_en,
  output logic [2:0] sel_field
);
  localparam int RW = $clog2(HOLD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] HOLD_V = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] RELOAD = RW'(HOLD_CYCLES - REPEAT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {RUN = 3'd0, S_MIN, S_HOUR, S_DAY, S_DATE, S_MONTH, S_YEAR, CLAMP} state_t;

  function automatic logic [4:0] max_days(input logic [3:0] m, input logic [6:0] y);
    return m == 4'd2 ? (y[1:0] == 2'd0 ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction

  state_t state, nxt;
  logic primed, mode_q, inc_q;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic mode_edge, inc_edge, rpt_fire, in_set, inc_go, clamp_go;
  logic [4:0] md;
  logic [6:0] inc_val, data_nxt;
  logic [5:0] ld_nxt;

  // primed masks the first sample after reset so a button held through reset is not an edge
  always_comb begin
    mode_edge = primed & btn_mode & ~mode_q;
    inc_edge  = primed & btn_inc & ~inc_q;
    rpt_fire  = btn_inc & (rcnt == HOLD_V);
    in_set    = state != RUN && state != CLAMP;
    md        = max_days(cur_month, cur_year);
    nxt       = state == CLAMP ? RUN :
                mode_edge ? state_t'(state + 3'd1) :
                (in_set && !inc_edge && tcnt == TO_LAST) ? CLAMP : state;
    inc_go    = in_set & (inc_edge | rpt_fire) & (nxt == state);
    clamp_go  = nxt == CLAMP && cur_date > md;
    inc_val   = state == S_MIN   ? (cur_min >= 6'd59 ? 7'd0 : 7'(cur_min) + 7'd1) :
                state == S_HOUR  ? (cur_hour >= 5'd23 ? 7'd0 : 7'(cur_hour) + 7'd1) :
                state == S_DAY   ? (cur_day >= 3'd7 ? 7'd1 : 7'(cur_day) + 7'd1) :
                state == S_DATE  ? (cur_date >= md ? 7'd1 : 7'(cur_date) + 7'd1) :
                state == S_MONTH ? (cur_month >= 4'd12 ? 7'd1 : 7'(cur_month) + 7'd1) :
                (cur_year >= 7'd99 ? 7'd0 : cur_year + 7'd1);
    ld_nxt    = (inc_go ? 6'd1 << (state - 3'd1) : 6'd0) | (clamp_go ? 6'b001000 : 6'd0);
    data_nxt  = clamp_go ? 7'(md) : inc_go ? inc_val : 7'd0;
    rcnt_nxt  = inc_edge ? RW'(1) :
                (btn_inc && rcnt != '0) ? (rpt_fire ? RELOAD : rcnt + RW'(1)) : '0;
    tcnt_nxt  = (mode_edge || inc_edge || nxt != state || !in_set) ? '0 : tcnt + TW'(1);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= RUN;
      primed    <= 1'b0;
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      rcnt      <= '0;
      tcnt      <= '0;
      {ld_year, ld_month, ld_date, ld_day, ld_hour, ld_min} <= 6'd0;
      set_data  <= 7'd0;
      run_en    <= 1'b1;
      sel_field <= 3'd0;
    end else begin
      state     <= nxt;
      primed    <= 1'b1;
      mode_q    <= btn_mode;
      inc_q     <= btn_inc;
      rcnt      <= rcnt_nxt;
      tcnt      <= tcnt_nxt;
      {ld_year, ld_month, ld_date, ld_day, ld_hour, ld_min} <= ld_nxt;
      set_data  <= data_nxt;
      run_en    <= nxt == RUN;
      sel_field <= (nxt == RUN || nxt == CLAMP) ? 3'd0 : 3'(nxt);
    end
  end
endmodule
